// File: rtl/addsub_sequencer_pkg.sv
// Shared opcodes, FSM states and default width for the TRISC adder/subtractor sequencer.
package addsub_sequencer_pkg;

   localparam int unsigned ADDSUB_W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NEG = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_DONE
   } state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= OP_CMP);
   endfunction

endpackage

// File: rtl/addsub_sequencer_flags.sv
// Result/flag formation for the sequencer; ADD/SUB saturate on overflow when ADDSUB_SAT_EN is defined.
module addsub_seq_flags
   import addsub_sequencer_pkg::*;
#(
   parameter int unsigned W = ADDSUB_W
) (
   input  logic [2:0]   op_i,
   input  logic [W-1:0] r_i,
   input  logic         cout_i,
   input  logic         ovr_i,
   input  logic [W-1:0] hi_i,
   input  logic         opa_msb_i,
   output logic [W-1:0] res_lo_o,
   output logic [W-1:0] res_hi_o,
   output logic         flag_c_o,
   output logic         flag_v_o,
   output logic         flag_z_o,
   output logic         flag_n_o
);

`ifdef ADDSUB_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   always_comb begin
      res_lo_o = r_i;
      res_hi_o = '0;
      flag_c_o = cout_i;
      flag_v_o = ovr_i;
      flag_z_o = 1'b0;
      flag_n_o = 1'b0;
      case (op_i)
         OP_MUL: begin
            res_hi_o = hi_i;
            flag_c_o = 1'b0;
            flag_v_o = |hi_i;
            flag_z_o = ({hi_i, r_i} == '0);
            flag_n_o = hi_i[W-1];
         end
         // CMP reports the difference's flags but hides the difference itself
         OP_CMP: begin
            res_lo_o = '0;
            flag_z_o = (r_i == '0);
            flag_n_o = r_i[W-1];
         end
         OP_ADD, OP_SUB: begin
            if (SAT_EN && ovr_i) begin
               res_lo_o = opa_msb_i ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
            flag_z_o = (res_lo_o == '0);
            flag_n_o = res_lo_o[W-1];
         end
         default: begin
            flag_z_o = (res_lo_o == '0);
            flag_n_o = res_lo_o[W-1];
         end
      endcase
   end

endmodule

// File: rtl/addsub_sequencer.sv
// Sequencer driving an external ripple adder/subtractor: ADD/SUB/NEG/CMP in one pass, MUL by shift-add.
// Optional ADD/SUB saturation is selected with the ADDSUB_SAT_EN macro.
module addsub_sequencer
   import addsub_sequencer_pkg::*;
#(
   parameter int unsigned W         = ADDSUB_W,
   parameter int unsigned MUL_ITERS = W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   output logic         add_c0,
   input  logic [W-1:0] add_r,
   input  logic         add_cout,
   input  logic         add_ovr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] res_lo,
   output logic [W-1:0] res_hi,
   output logic         flag_c,
   output logic         flag_v,
   output logic         flag_z,
   output logic         flag_n,
   output logic         err
);

   localparam int unsigned CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

   state_e         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic           c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d, err_q, err_d;

   logic [W-1:0]   mul_hi_nx, mul_lo_nx;
   logic [W-1:0]   f_r, f_hi, f_lo, f_hi_o;
   logic           f_c, f_v, f_z, f_n;

   // Adder inputs depend on registered state only, keeping the external adder path acyclic
   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_c0 = 1'b0;
      case (state_q)
         S_EXEC: begin
            add_a  = (op_q == OP_NEG) ? '0 : opa_q;
            add_b  = (op_q == OP_NEG) ? opa_q : opb_q;
            add_c0 = (op_q != OP_ADD);
         end
         S_MUL: begin
            add_a = hi_q;
            add_b = opa_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      if (lo_q[0]) begin
         {mul_hi_nx, mul_lo_nx} = {add_cout, add_r, lo_q[W-1:1]};
      end else begin
         {mul_hi_nx, mul_lo_nx} = {1'b0, hi_q, lo_q[W-1:1]};
      end
   end

   assign f_r  = (state_q == S_MUL) ? mul_lo_nx : add_r;
   assign f_hi = (state_q == S_MUL) ? mul_hi_nx : '0;

   addsub_seq_flags #(.W(W)) u_flags (
      .op_i      (op_q),
      .r_i       (f_r),
      .cout_i    (add_cout),
      .ovr_i     (add_ovr),
      .hi_i      (f_hi),
      .opa_msb_i (opa_q[W-1]),
      .res_lo_o  (f_lo),
      .res_hi_o  (f_hi_o),
      .flag_c_o  (f_c),
      .flag_v_o  (f_v),
      .flag_z_o  (f_z),
      .flag_n_o  (f_n)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      c_d      = c_q;
      v_d      = v_q;
      z_d      = z_q;
      n_d      = n_q;
      err_d    = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_d     = op;
               opa_d    = opa;
               opb_d    = opb;
               hi_d     = '0;
               lo_d     = opb;
               cnt_d    = '0;
               res_lo_d = '0;
               res_hi_d = '0;
               c_d      = 1'b0;
               v_d      = 1'b0;
               z_d      = 1'b0;
               n_d      = 1'b0;
               err_d    = !op_is_legal(op);
               if (!op_is_legal(op)) begin
                  state_d = S_DONE;
               end else if (op == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC, S_MUL: begin
            if (state_q == S_MUL) begin
               hi_d  = mul_hi_nx;
               lo_d  = mul_lo_nx;
               cnt_d = cnt_q + 1'b1;
            end
            if (state_q == S_EXEC || cnt_q == LAST) begin
               res_lo_d = f_lo;
               res_hi_d = f_hi_o;
               c_d      = f_c;
               v_d      = f_v;
               z_d      = f_z;
               n_d      = f_n;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         c_q      <= c_d;
         v_q      <= v_d;
         z_q      <= z_d;
         n_q      <= n_d;
         err_q    <= err_d;
      end
   end

   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;
   assign flag_c = c_q;
   assign flag_v = v_q;
   assign flag_z = z_q;
   assign flag_n = n_q;
   assign err    = err_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Scoreboard bench for addsub_sequencer with a behavioural adder and an arithmetic reference model.
module tb_addsub_sequencer;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic [2:0] op;
   logic [7:0] opa, opb;
   logic [7:0] add_a, add_b, add_r;
   logic       add_c0, add_cout, add_ovr;
   logic       out_valid, out_ready;
   logic [7:0] res_lo, res_hi;
   logic       flag_c, flag_v, flag_z, flag_n, err;

   always #5 clk = ~clk;

   // External ripple adder: R = A + (C0 ? ~B : B) + C0
   logic [7:0] bb;
   always_comb begin
      bb = add_c0 ? ~add_b : add_b;
      {add_cout, add_r} = {1'b0, add_a} + {1'b0, bb} + {8'd0, add_c0};
      add_ovr = (add_a[7] == bb[7]) && (add_r[7] != add_a[7]);
   end

   addsub_sequencer #(.W(8), .MUL_ITERS(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .opa(opa), .opb(opb),
      .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
      .add_r(add_r), .add_cout(add_cout), .add_ovr(add_ovr),
      .out_valid(out_valid), .out_ready(out_ready),
      .res_lo(res_lo), .res_hi(res_hi),
      .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .err(err)
   );

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic       c, v, z, n, e;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   bp_force = 1'b0;
   bit   bp_val = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int ua, ub, sa, sb, r, sv, p;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      e.lo = 8'd0; e.hi = 8'd0;
      e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.n = 1'b0; e.e = 1'b0;
      e.lat = 2; e.acc = 0;
      r = 0; sv = 0;
      case (o)
         3'd0: begin r = ua + ub; e.c = (r > 255); sv = sa + sb; end
         3'd1, 3'd4: begin r = ua - ub; e.c = (ua >= ub); sv = sa - sb; end
         3'd2: begin r = -ua; e.c = (ua == 0); sv = -sa; end
         3'd3: begin
            p = ua * ub;
            e.hi = 8'(p / 256);
            e.lo = 8'(p % 256);
            e.v = (p > 255);
            e.z = (p == 0);
            e.n = (p >= 32768);
            e.lat = 9;
            return e;
         end
         default: begin
            e.e = 1'b1;
            e.lat = 1;
            return e;
         end
      endcase
      e.v = (sv > 127) || (sv < -128);
      e.lo = 8'(r & 255);
      if (SAT && e.v && (o == 3'd0 || o == 3'd1)) e.lo = a[7] ? 8'h80 : 8'h7F;
      e.z = (e.lo == 8'd0);
      e.n = e.lo[7];
      if (o == 3'd4) e.lo = 8'd0;
      return e;
   endfunction

   // Monitor: checks hold-stability under back-pressure, latency, and results on handshake
   bit         pend = 1'b0;
   logic [20:0] snap;
   always @(negedge clk) begin
      exp_t e;
      logic [20:0] cur;
      cur = {res_hi, res_lo, flag_c, flag_v, flag_z, flag_n, err};
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("valid_held", {31'd0, out_valid}, 32'd1);
            chk("hold_stable", {11'd0, cur}, {11'd0, snap});
         end else if (out_valid) begin
            if (sbq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("latency", cyc - sbq[0].acc, sbq[0].lat);
         end
         if (out_valid) begin
            chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
            if (out_ready && sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("result", {11'd0, cur}, {11'd0, e.hi, e.lo, e.c, e.v, e.z, e.n, e.e});
            end
         end
         pend = out_valid && !out_ready;
         snap = cur;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_force ? bp_val : (($urandom % 4) != 0);
      end
   end

   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      e = model(o, a, b);
      e.acc = cyc;
      sbq.push_back(e);
      in_valid = 1'b1;
      op = o; opa = a; opb = b;
      @(negedge clk);
      in_valid = 1'b0;
      op = 3'($urandom); opa = 8'($urandom); opb = 8'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 32'd0);
   endtask

   task automatic check_idle_after_reset(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_outputs"}, {11'd0, res_hi, res_lo, flag_c, flag_v, flag_z, flag_n, err}, 32'd0);
      chk({tag, "_adder_in"}, {15'd0, add_a, add_b, add_c0}, 32'd0);
   endtask

   initial begin
      int t;
      rst = 1'b1; in_valid = 1'b0; op = '0; opa = '0; opb = '0;
      repeat (3) @(negedge clk);
      check_idle_after_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      issue(3'd0, 8'h7F, 8'h01);
      issue(3'd1, 8'h05, 8'h05);
      issue(3'd4, 8'h03, 8'h05);
      issue(3'd2, 8'h80, 8'h00);
      issue(3'd2, 8'h01, 8'h00);
      issue(3'd3, 8'h0F, 8'h11);
      issue(3'd3, 8'hFF, 8'hFF);
      issue(3'd7, 8'h12, 8'h34);
      drain();

      // Back-pressure: hold out_ready low and poke in_valid while the result waits
      bp_force = 1'b1; bp_val = 1'b0;
      @(negedge clk);
      issue(3'd0, 8'h10, 8'h20);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
      repeat (3) begin
         in_valid = 1'b1; op = 3'd1; opa = 8'($urandom); opb = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      bp_force = 1'b0;
      drain();

      // Reset during the 4th MUL iteration discards the operation
      issue(3'd3, 8'hAB, 8'hCD);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      check_idle_after_reset("midmul_reset");
      rst = 1'b0;
      @(negedge clk);
      issue(3'd0, 8'h02, 8'h03);
      drain();

      for (int i = 0; i < 150; i++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         if ($urandom % 3 == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
